// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe
//   N-way, W-bit select mux whose output sits in a 2-entry skid buffer with a
//   valid/ready handshake. The select path ends at the main register, and the
//   downstream stall path ends at the registered in_ready.
//
// Parameters
//   WIDTH  data word width in bits
//   NUM    number of input channels (>= 2)
//   SEL_W  select width, 2**SEL_W >= NUM
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    NUM packed words, channel k at [k*WIDTH +: WIDTH]
//   in_sel     channel index, qualified by in_valid
//   in_valid   upstream word valid
//   in_ready   block can accept (registered)
//   out_data   selected word (main register)
//   out_sel    clamped index that was actually used
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   sel_err    (SEL_MUX_RANGE_ERR_EN only) sticky out-of-range select flag
//   err_clr    (SEL_MUX_RANGE_ERR_EN only) clears sel_err on the next edge
//
// Build option
//   SEL_MUX_RANGE_ERR_EN  adds the sel_err/err_clr ports. Without it the
//                         out-of-range clamp to NUM-1 still applies.

module sel_mux_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM   = 6,
  parameter int unsigned SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef SEL_MUX_RANGE_ERR_EN
  ,
  output logic                 sel_err,
  input  logic                 err_clr
`endif
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  // One extra bit so the compare stays correct when NUM == 2**SEL_W.
  localparam logic [SEL_W:0]   NumExt  = (SEL_W + 1)'(NUM);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q, in_ready_d;

  logic             in_range;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] sel_word;
  logic             accept;
  logic             pop;

  // Channel selection with clamp of out-of-range indices to the last channel.
  always_comb begin
    in_range = ({1'b0, in_sel} < NumExt);
    idx      = in_range ? in_sel : LastIdx;
    sel_word = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (idx == SEL_W'(k)) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign in_ready  = in_ready_q;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          main_data_d = sel_word;
          main_sel_d  = idx;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_data_d = sel_word;
          main_sel_d  = idx;
        end else if (accept) begin
          // Downstream stalled: park the new word behind the held one.
          state_d     = StTwo;
          skid_data_d = sel_word;
          skid_sel_d  = idx;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d     = StOne;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase

    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef SEL_MUX_RANGE_ERR_EN
  logic sel_err_q, sel_err_d;

  // Set has priority over clear when both land in the same cycle.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && !in_range) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe
//   Self-checking bench for sel_mux_pipe. A queue of expected {sel, data}
//   words models the buffer: its length is the occupancy, its head is the
//   word on the output.

module tb_sel_mux_pipe;

  localparam int WIDTH = 32;
  localparam int NUM   = 6;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } word_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready;
`ifdef SEL_MUX_RANGE_ERR_EN
  logic                 sel_err;
  logic                 err_clr;
`endif

  word_t m_q[$];
  logic  m_err;
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  sel_mux_pipe #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .SEL_W (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEL_MUX_RANGE_ERR_EN
    ,
    .sel_err   (sel_err),
    .err_clr   (err_clr)
`endif
  );

  function automatic logic [NUM*WIDTH-1:0] chan_pattern();
    logic [NUM*WIDTH-1:0] d;
    for (int k = 0; k < NUM; k++) d[k*WIDTH +: WIDTH] = 32'h1000_0000 + k;
    return d;
  endfunction

  function automatic logic [NUM*WIDTH-1:0] rand_data();
    logic [NUM*WIDTH-1:0] d;
    for (int k = 0; k < NUM; k++) d[k*WIDTH +: WIDTH] = $urandom;
    return d;
  endfunction

  function automatic word_t pick(input logic [SEL_W-1:0] s, input logic [NUM*WIDTH-1:0] d);
    word_t w;
    int    i;
    i      = (int'(s) < NUM) ? int'(s) : NUM - 1;
    w.sel  = i[SEL_W-1:0];
    w.data = d[i*WIDTH +: WIDTH];
    return w;
  endfunction

  // Drive one cycle of inputs at the falling edge, let the rising edge happen,
  // advance the model, and return 1 time unit after the edge.
  task automatic drive_cycle(input logic v, input logic [SEL_W-1:0] s,
                             input logic [NUM*WIDTH-1:0] d, input logic ordy);
    bit acc, pop;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    acc = v && (m_q.size() < 2);
    pop = ordy && (m_q.size() > 0);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(pick(s, d));
`ifdef SEL_MUX_RANGE_ERR_EN
    if (acc && int'(s) >= NUM) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
`endif
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, rand_data(), 1'b1);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    tests++;
    if (out_data !== '0 || out_sel !== '0) begin
      fails++; $display("FAIL reset_out: got data %h sel %0d want 0/0", out_data, out_sel);
    end
`ifdef SEL_MUX_RANGE_ERR_EN
    tests++;
    if (sel_err !== 1'b0) begin
      fails++; $display("FAIL reset_sel_err: got %0b want 0", sel_err);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_select_seq();
    for (int s = 0; s < NUM; s++) begin
      drive_cycle(1'b1, SEL_W'(s), chan_pattern(), 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + s || out_sel !== SEL_W'(s)) begin
        fails++;
        $display("FAIL select_seq[%0d]: got v=%0b data=%h sel=%0d want v=1 data=%h sel=%0d",
                 s, out_valid, out_data, out_sel, 32'h1000_0000 + s, s);
      end
      tests++;
      if (in_ready !== 1'b1) begin
        fails++; $display("FAIL select_seq_ready[%0d]: got %0b want 1", s, in_ready);
      end
    end
    drive_cycle(1'b0, '0, chan_pattern(), 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL select_seq_drain: got out_valid %0b want 0", out_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [SEL_W-1:0] s;
    for (int j = NUM; j < (1 << SEL_W); j++) begin
      s = SEL_W'(j);
      drive_cycle(1'b1, s, chan_pattern(), 1'b1);
      tests++;
      if (out_data !== 32'h1000_0005 || out_sel !== SEL_W'(NUM - 1)) begin
        fails++;
        $display("FAIL out_of_range[%0d]: got data=%h sel=%0d want data=10000005 sel=%0d",
                 j, out_data, out_sel, NUM - 1);
      end
    end
    drain();
`ifdef SEL_MUX_RANGE_ERR_EN
    tests++;
    if (sel_err !== 1'b1) begin
      fails++; $display("FAIL sel_err_sticky: got %0b want 1", sel_err);
    end
    // Set and clear in the same cycle: set wins.
    err_clr = 1'b1;
    drive_cycle(1'b1, 3'd7, chan_pattern(), 1'b1);
    tests++;
    if (sel_err !== m_err || m_err !== 1'b1) begin
      fails++; $display("FAIL sel_err_set_wins: got %0b want 1", sel_err);
    end
    drive_cycle(1'b0, 3'd7, chan_pattern(), 1'b1);
    err_clr = 1'b0;
    tests++;
    if (sel_err !== 1'b0) begin
      fails++; $display("FAIL sel_err_clear: got %0b want 0", sel_err);
    end
    drain();
`endif
  endtask

  task automatic test_stall();
    logic [NUM*WIDTH-1:0] d;
    d = chan_pattern();
    drive_cycle(1'b1, 3'd1, d, 1'b0);  // A
    drive_cycle(1'b1, 3'd2, d, 1'b0);  // B
    tests++;
    if (in_ready !== 1'b0 || out_data !== 32'h1000_0001 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL stall_two: got ready=%0b data=%h v=%0b want ready=0 data=10000001 v=1",
               in_ready, out_data, out_valid);
    end
    // C offered while full, plus churn on ignored inputs: outputs must hold.
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 3'd3, rand_data(), 1'b0);
      tests++;
      if (out_data !== 32'h1000_0001 || out_sel !== 3'd1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got data=%h sel=%0d ready=%0b want 10000001/1/0",
                 i, out_data, out_sel, in_ready);
      end
    end
    drive_cycle(1'b0, 3'd3, d, 1'b1);  // pop A
    tests++;
    if (out_data !== 32'h1000_0002 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_pop_a: got data=%h ready=%0b want 10000002/1", out_data, in_ready);
    end
    drive_cycle(1'b1, 3'd3, d, 1'b1);  // pop B, accept C
    tests++;
    if (out_data !== 32'h1000_0003 || out_valid !== 1'b1) begin
      fails++; $display("FAIL stall_c: got data=%h v=%0b want 10000003/1", out_data, out_valid);
    end
    drain();
  endtask

  task automatic test_accept_pop();
    logic [NUM*WIDTH-1:0] d;
    d = rand_data();
    drive_cycle(1'b1, 3'd0, d, 1'b0);
    drive_cycle(1'b1, 3'd4, d, 1'b1);
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== d[4*WIDTH +: WIDTH] ||
        out_sel !== 3'd4) begin
      fails++;
      $display("FAIL accept_pop: got v=%0b ready=%0b data=%h sel=%0d want 1/1/%h/4",
               out_valid, in_ready, out_data, out_sel, d[4*WIDTH +: WIDTH]);
    end
    drain();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 10000; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 7)), rand_data(),
                  1'($urandom_range(0, 3) != 0));
      tests++;
      if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2)) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL random_flags[%0d]: got v=%0b ready=%0b want occupancy %0d",
                               c, out_valid, in_ready, m_q.size());
      end else if (m_q.size() > 0) begin
        tests++;
        if (out_data !== m_q[0].data || out_sel !== m_q[0].sel) begin
          fails++; bad++;
          if (bad < 10) $display("FAIL random_data[%0d]: got %h/%0d want %h/%0d",
                                 c, out_data, out_sel, m_q[0].data, m_q[0].sel);
        end
      end
    end
    drain();
    tests++;
    if (out_valid !== 1'b0 || m_q.size() != 0) begin
      fails++; $display("FAIL random_drain: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 3'd2, chan_pattern(), 1'b0);
    drive_cycle(1'b1, 3'd3, chan_pattern(), 1'b0);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid_pre: got ready=%0b want 0", in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_async: got v=%0b data=%h sel=%0d ready=%0b want 0/0/0/1",
               out_valid, out_data, out_sel, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_err = 1'b0;
    drive_cycle(1'b1, 3'd4, chan_pattern(), 1'b1);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h1000_0004 || out_sel !== 3'd4) begin
      fails++;
      $display("FAIL reset_mid_post: got v=%0b data=%h sel=%0d want 1/10000004/4",
               out_valid, out_data, out_sel);
    end
    drive_cycle(1'b0, 3'd0, chan_pattern(), 1'b1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_dup: got v=%0b want 0", out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_err     = 1'b0;
`ifdef SEL_MUX_RANGE_ERR_EN
    err_clr   = 1'b0;
`endif
    test_reset();
    test_select_seq();
    test_out_of_range();
    test_stall();
    test_accept_pop();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
